// File: rtl/datapath_pkg.sv
// datapath_pkg: opcodes, FSM states and control encodings shared by the datapath sequencer
package datapath_pkg;
  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000, OP_SUB = 5'b00001, OP_AND = 5'b00010, OP_OR  = 5'b00011,
    OP_XOR  = 5'b00100, OP_NOT = 5'b00101, OP_ADDI = 5'b01000, OP_LDW = 5'b10000,
    OP_STW  = 5'b10001, OP_B   = 5'b11000, OP_BZ  = 5'b11001, OP_BL  = 5'b11010
  } opcode_t;
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, MEM} state_t;
  typedef enum logic [1:0] {CL_ALU, CL_MEM, CL_BR, CL_BAD} opclass_t;
  typedef struct packed {
    logic zero_a, sub, cin, fa, and_op, or_op, xor_op, not_op;
  } alu_ctrl_t;
  localparam logic [2:0] PC_INC = 3'b001, PC_ALU = 3'b010, PC_LR = 3'b100;
  localparam logic [1:0] OP2_IMM = 2'd0, OP2_RD2 = 2'd1, OP2_ZERO = 2'd2;
  function automatic opclass_t op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADDI: return CL_ALU;
      OP_LDW, OP_STW: return CL_MEM;
      OP_B, OP_BZ, OP_BL: return CL_BR;
      default: return CL_BAD;
    endcase
  endfunction
endpackage

// File: rtl/datapath_ctrl_alu_decode.sv
// alu_decode: opcode to ALU function controls; undefined opcodes select nothing
module alu_decode
  import datapath_pkg::*;
(
  input  logic [4:0] op,
  output alu_ctrl_t  ctl
);
  always_comb begin
    ctl = '0;
    case (op)
      OP_SUB: begin
        ctl.fa  = 1'b1;
        ctl.sub = 1'b1;
        ctl.cin = 1'b1;
      end
      OP_AND: ctl.and_op = 1'b1;
      OP_OR:  ctl.or_op  = 1'b1;
      OP_XOR: ctl.xor_op = 1'b1;
      OP_NOT: ctl.not_op = 1'b1;
      OP_ADD, OP_ADDI, OP_LDW, OP_STW, OP_B, OP_BZ, OP_BL: ctl.fa = 1'b1;
      default: ctl = '0;
    endcase
  end
endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: fetch/decode/execute sequencer driving every control line of the bit-sliced datapath
module datapath_ctrl
  import datapath_pkg::*;
#(
  parameter int IMM_W = 5,
  parameter int NREGS = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [15:0]      IrIn,
  input  logic             MemAck,
  input  logic             nZ,
  output logic             MemReq,
  output logic             MemWe,
  output logic             DrBus,
  output logic [NREGS-1:0] Rw,
  output logic [NREGS-1:0] Rs1,
  output logic [NREGS-1:0] Rs2,
  output logic             WdSel,
  output logic             Op1Sel,
  output logic [1:0]       Op2Sel,
  output logic [15:0]      Imm,
  output logic             ZeroA,
  output logic             SUB,
  output logic             CIn,
  output logic             FAOut,
  output logic             AND,
  output logic             OR,
  output logic             XOR,
  output logic             NOT,
  output logic             AluOut,
  output logic [2:0]       PcSel,
  output logic             PcWe,
  output logic             PcIncCin,
  output logic             LrWe,
  output logic             LrSel,
  output logic             Illegal
);
  state_t           state, next;
  logic [15:0]      ir, imm;
  logic             z, quiet, load_ir, set_z;
  logic [4:0]       op;
  opclass_t         cls;
  alu_ctrl_t        ac, alu;
  logic [NREGS-1:0] oh_rd, oh_ra, oh_rb;
  assign op    = ir[15:11];
  assign cls   = op_class(op);
  assign oh_rd = NREGS'(1) << ir[10:8];
  assign oh_ra = NREGS'(1) << ir[7:5];
  assign oh_rb = NREGS'(1) << ir[4:2];
  assign imm   = {{(16-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  assign {ZeroA, SUB, CIn, FAOut, AND, OR, XOR, NOT} = alu;
  alu_decode u_alu (.op(op), .ctl(ac));
  // quiet holds every output low for one cycle after reset so a stale MemAck cannot be taken
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= FETCH;
      ir    <= '0;
      z     <= 1'b0;
      quiet <= 1'b1;
    end else begin
      state <= next;
      quiet <= 1'b0;
      if (load_ir) ir <= IrIn;
      if (set_z) z <= ~nZ;
    end
  end
  always_comb begin
    next     = state;
    load_ir  = 1'b0;
    set_z    = 1'b0;
    MemReq   = 1'b0;
    MemWe    = 1'b0;
    DrBus    = 1'b0;
    Rw       = '0;
    Rs1      = '0;
    Rs2      = '0;
    WdSel    = 1'b0;
    Op1Sel   = 1'b0;
    Op2Sel   = OP2_IMM;
    Imm      = '0;
    alu      = '0;
    AluOut   = 1'b0;
    PcSel    = '0;
    PcWe     = 1'b0;
    PcIncCin = 1'b0;
    LrWe     = 1'b0;
    LrSel    = 1'b0;
    Illegal  = 1'b0;
    if (!quiet) begin
      case (state)
        FETCH: begin
          MemReq = 1'b1;
          Op1Sel = 1'b1;
          Op2Sel = OP2_ZERO;
          alu.fa = 1'b1;
          AluOut = 1'b1;
          if (MemAck) begin
            load_ir  = 1'b1;
            PcWe     = 1'b1;
            PcSel    = PC_INC;
            PcIncCin = 1'b1;
            next     = DECODE;
          end
        end
        DECODE: begin
          Rs1  = oh_ra;
          Rs2  = oh_rb;
          Imm  = imm;
          next = EXEC;
        end
        EXEC: begin
          Imm  = imm;
          next = FETCH;
          if (cls == CL_ALU) begin
            Rs1    = oh_ra;
            Rs2    = oh_rb;
            Op2Sel = (op == OP_ADDI) ? OP2_IMM : OP2_RD2;
            alu    = ac;
            Rw     = oh_rd;
            set_z  = 1'b1;
          end else if (cls == CL_MEM) begin
            Rs1    = oh_ra;
            alu    = ac;
            AluOut = 1'b1;
            next   = MEM;
          end else if (cls == CL_BR) begin
            Op1Sel = 1'b1;
            alu    = ac;
            PcSel  = PC_ALU;
            PcWe   = (op != OP_BZ) || z;
            LrWe   = (op == OP_BL);
          end else begin
            Illegal = 1'b1;
          end
        end
        MEM: begin
          MemReq = 1'b1;
          Rs1    = oh_ra;
          Imm    = imm;
          alu    = ac;
          AluOut = 1'b1;
          if (op == OP_STW) begin
            MemWe = 1'b1;
            DrBus = 1'b1;
            Rs2   = oh_rd;
          end else if (MemAck) begin
            Rw    = oh_rd;
            WdSel = 1'b1;
          end
          if (MemAck) next = FETCH;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: randomized scoreboard bench; driver queues expected per-cycle outputs, monitor compares
module tb_datapath_ctrl;
  import datapath_pkg::*;
  logic        clk = 1'b0;
  logic        Reset, MemAck, nZ;
  logic [15:0] IrIn;
  logic        MemReq, MemWe, DrBus, WdSel, Op1Sel;
  logic [7:0]  Rw, Rs1, Rs2;
  logic [1:0]  Op2Sel;
  logic [15:0] Imm;
  logic        ZeroA, SUB, CIn, FAOut, AND, OR, XOR, NOT, AluOut;
  logic [2:0]  PcSel;
  logic        PcWe, PcIncCin, LrWe, LrSel, Illegal;
  typedef struct packed {
    logic       mreq, mwe, drbus;
    logic [7:0] rw, rs1, rs2;
    logic       wdsel, op1;
    logic [1:0] op2;
    logic [15:0] imm;
    logic [7:0] alu;
    logic       aluout;
    logic [2:0] pcsel;
    logic       pcwe, pcinc, lrwe, lrsel, illegal;
  } exp_t;
  typedef struct {
    exp_t  v;
    string nm;
  } rec_t;
  localparam logic [7:0] A_FA = 8'h10, A_SUB = 8'h70, A_AND = 8'h08, A_OR = 8'h04,
                         A_XOR = 8'h02, A_NOT = 8'h01;
  localparam logic [4:0] OPS [12] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
                                      OP_ADDI, OP_LDW, OP_STW, OP_B, OP_BZ, OP_BL};
  rec_t q[$];
  rec_t r;
  exp_t got;
  int   tests = 0, fails = 0;
  logic z_m = 1'b0;
  datapath_ctrl dut (
    .Clock(clk), .Reset(Reset), .IrIn(IrIn), .MemAck(MemAck), .nZ(nZ),
    .MemReq(MemReq), .MemWe(MemWe), .DrBus(DrBus), .Rw(Rw), .Rs1(Rs1), .Rs2(Rs2),
    .WdSel(WdSel), .Op1Sel(Op1Sel), .Op2Sel(Op2Sel), .Imm(Imm),
    .ZeroA(ZeroA), .SUB(SUB), .CIn(CIn), .FAOut(FAOut), .AND(AND), .OR(OR), .XOR(XOR),
    .NOT(NOT), .AluOut(AluOut), .PcSel(PcSel), .PcWe(PcWe), .PcIncCin(PcIncCin),
    .LrWe(LrWe), .LrSel(LrSel), .Illegal(Illegal)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] oh(input logic [2:0] x);
    return 8'(1) << x;
  endfunction
  function automatic logic [15:0] sext(input logic [15:0] i);
    return {{11{i[4]}}, i[4:0]};
  endfunction
  function automatic bit is_alu(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADDI};
  endfunction
  function automatic bit is_mem(input logic [4:0] op);
    return op inside {OP_LDW, OP_STW};
  endfunction
  function automatic logic [7:0] alu_of(input logic [4:0] op);
    case (op)
      OP_SUB:  return A_SUB;
      OP_AND:  return A_AND;
      OP_OR:   return A_OR;
      OP_XOR:  return A_XOR;
      OP_NOT:  return A_NOT;
      default: return A_FA;
    endcase
  endfunction
  function automatic exp_t fetch_rec(input logic ack);
    exp_t e = '0;
    e.mreq = 1; e.op1 = 1; e.op2 = OP2_ZERO; e.alu = A_FA; e.aluout = 1;
    if (ack) begin
      e.pcwe = 1; e.pcsel = PC_INC; e.pcinc = 1;
    end
    return e;
  endfunction
  function automatic exp_t decode_rec(input logic [15:0] i);
    exp_t e = '0;
    e.rs1 = oh(i[7:5]); e.rs2 = oh(i[4:2]); e.imm = sext(i);
    return e;
  endfunction
  function automatic exp_t exec_rec(input logic [15:0] i);
    exp_t e = '0;
    logic [4:0] op = i[15:11];
    e.imm = sext(i);
    if (is_alu(op)) begin
      e.rs1 = oh(i[7:5]); e.rs2 = oh(i[4:2]); e.rw = oh(i[10:8]);
      e.op2 = (op == OP_ADDI) ? OP2_IMM : OP2_RD2; e.alu = alu_of(op);
    end else if (is_mem(op)) begin
      e.rs1 = oh(i[7:5]); e.op2 = OP2_IMM; e.alu = A_FA; e.aluout = 1;
    end else if (op inside {OP_B, OP_BZ, OP_BL}) begin
      e.op1 = 1; e.op2 = OP2_IMM; e.alu = A_FA; e.pcsel = PC_ALU;
      e.pcwe = (op == OP_BZ) ? z_m : 1'b1; e.lrwe = (op == OP_BL);
    end else begin
      e.illegal = 1;
    end
    return e;
  endfunction
  function automatic exp_t mem_rec(input logic [15:0] i, input logic ack);
    exp_t e = '0;
    e.mreq = 1; e.rs1 = oh(i[7:5]); e.op2 = OP2_IMM; e.imm = sext(i); e.alu = A_FA; e.aluout = 1;
    if (i[15:11] == OP_STW) begin
      e.mwe = 1; e.drbus = 1; e.rs2 = oh(i[10:8]);
    end else if (ack) begin
      e.rw = oh(i[10:8]); e.wdsel = 1;
    end
    return e;
  endfunction
  task automatic cyc(input logic ack, input logic [15:0] irin, input logic nz, input exp_t e,
                     input string nm);
    MemAck = ack; IrIn = irin; nZ = nz;
    q.push_back('{v: e, nm: nm});
    @(posedge clk); #1;
  endtask
  task automatic front(input logic [15:0] i, input int fw, input logic nz);
    for (int k = 0; k < fw; k++) cyc(1'b0, 16'($urandom), 1'($urandom), fetch_rec(1'b0), "fetch_wait");
    cyc(1'b1, i, 1'($urandom), fetch_rec(1'b1), "fetch");
    cyc(1'($urandom), 16'($urandom), 1'($urandom), decode_rec(i), "decode");
    cyc(1'($urandom), 16'($urandom), nz, exec_rec(i), "exec");
    if (is_alu(i[15:11])) z_m = ~nz;
  endtask
  task automatic run(input logic [15:0] i, input int fw, input int mw, input logic nz);
    front(i, fw, nz);
    if (is_mem(i[15:11])) begin
      for (int k = 0; k < mw; k++) cyc(1'b0, 16'($urandom), 1'($urandom), mem_rec(i, 1'b0), "mem_wait");
      cyc(1'b1, 16'($urandom), 1'($urandom), mem_rec(i, 1'b1), "mem_ack");
    end
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      r = q.pop_front();
      got = {MemReq, MemWe, DrBus, Rw, Rs1, Rs2, WdSel, Op1Sel, Op2Sel, Imm,
             ZeroA, SUB, CIn, FAOut, AND, OR, XOR, NOT, AluOut, PcSel, PcWe, PcIncCin,
             LrWe, LrSel, Illegal};
      tests++;
      if (got !== r.v) begin
        fails++;
        $display("FAIL %s: got %h expected %h", r.nm, got, r.v);
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end
  initial begin
    logic [15:0] stw, i;
    Reset = 1; MemAck = 1; IrIn = 16'h1234; nZ = 0;
    @(posedge clk); #1;
    cyc(1'b1, 16'h1234, 1'b0, '0, "reset_hold");
    Reset = 0;
    cyc(1'b1, 16'h1234, 1'b0, '0, "post_reset");
    run(16'h0188, 0, 0, 1'b1);
    run({OP_LDW, 3'd3, 3'd1, 5'd6}, 1, 3, 1'b0);
    run({OP_SUB, 3'd2, 3'd1, 5'd4}, 0, 0, 1'b0);
    run({OP_BZ, 3'd0, 3'd0, 5'h1F}, 0, 0, 1'b1);
    run({OP_SUB, 3'd2, 3'd1, 5'd4}, 0, 0, 1'b1);
    run({OP_BZ, 3'd0, 3'd0, 5'h1F}, 0, 0, 1'b0);
    run({OP_BL, 3'd0, 3'd0, 5'h03}, 0, 0, 1'b0);
    run(16'hF800, 0, 0, 1'b0);
    stw = {OP_STW, 3'd5, 3'd2, 5'h11};
    front(stw, 0, 1'b0);
    cyc(1'b0, 16'($urandom), 1'b0, mem_rec(stw, 1'b0), "stw_mem");
    Reset = 1;
    cyc(1'b0, 16'($urandom), 1'b0, mem_rec(stw, 1'b0), "stw_mem_reset");
    Reset = 0; z_m = 0;
    tests++;
    if (dut.ir !== 16'h0 || dut.state !== FETCH) begin
      fails++;
      $display("FAIL reset_mid_mem: got ir=%h state=%0d expected ir=0000 state=%0d", dut.ir, dut.state, FETCH);
    end
    cyc(1'b1, 16'hFFFF, 1'b0, '0, "after_reset_quiet");
    run({OP_BZ, 3'd0, 3'd0, 5'h05}, 0, 0, 1'b0);
    for (int n = 0; n < 300; n++) begin
      i = {(($urandom_range(0, 3) == 0) ? 5'($urandom) : OPS[$urandom_range(0, 11)]), 11'($urandom)};
      run(i, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
    end
    MemAck = 0;
    repeat (2) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
